// File: rtl/tge_tx_packetizer.sv
// tge_tx_packetizer
// Buffers a continuous 64-bit sample stream in an internal FIFO and frames it
// into fixed-size UDP payloads for the 10GbE core's application TX interface.
// Each packet optionally starts with a header word {HEADER_ID, seq[47:0]}.
//
// Ports:
//   clk, rst          application clock, synchronous active-high reset
//   enable            permits new packets to start
//   dest_ip/dest_port destination, latched at packet start
//   in_valid/in_data  input word stream; in_full flags that a word is dropped
//   tx_*              registered outputs to the core TX interface
//   tx_afull          core almost-full, checked only at packet start
//   tx_overflow       core overflow flag, counted per cycle
//   pkt_count         packets completed (wraps)
//   drop_count        input words dropped (saturates)
//   ovf_count         cycles with tx_overflow high (saturates)
//   busy              state machine not idle
module tge_tx_packetizer #(
   parameter int unsigned PAYLOAD_WORDS = 128,
   parameter int unsigned FIFO_AW       = 9,
   parameter int unsigned HEADER_ENABLE = 1,
   parameter logic [15:0] HEADER_ID     = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [31:0] dest_ip,
   input  logic [15:0] dest_port,
   input  logic        in_valid,
   input  logic [63:0] in_data,
   output logic        in_full,
   output logic        tx_valid,
   output logic        tx_end_of_frame,
   output logic [63:0] tx_data,
   output logic [31:0] tx_dest_ip,
   output logic [15:0] tx_dest_port,
   input  logic        tx_afull,
   input  logic        tx_overflow,
   output logic [31:0] pkt_count,
   output logic [31:0] drop_count,
   output logic [15:0] ovf_count,
   output logic        busy
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_L = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [FIFO_AW:0] PW_L    = (FIFO_AW+1)'(PAYLOAD_WORDS);
   localparam logic [FIFO_AW:0] PW_LAST = PW_L - 1'b1;

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_e;

   state_e              state_q, state_d;
   logic [63:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]    count_q, count_d;
   logic                full_q;
   logic [FIFO_AW:0]    wcnt_q, wcnt_d;
   logic [47:0]         seq_q, seq_d;
   logic                tx_valid_q, tx_valid_d;
   logic                tx_eof_q, tx_eof_d;
   logic [63:0]         tx_data_q, tx_data_d;
   logic [31:0]         tx_ip_q, tx_ip_d;
   logic [15:0]         tx_port_q, tx_port_d;
   logic [31:0]         pkt_q, pkt_d;
   logic [31:0]         drop_q;
   logic [15:0]         ovf_q;
   logic                push, pop, drop;

   // The full flag tracks the occupancy register; a word presented while it
   // is high is dropped even if a read frees a slot in the same cycle.
   assign push = in_valid && !full_q;
   assign drop = in_valid && full_q;

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      seq_d      = seq_q;
      pkt_d      = pkt_q;
      pop        = 1'b0;
      tx_valid_d = 1'b0;
      tx_eof_d   = 1'b0;
      tx_data_d  = '0;
      tx_ip_d    = tx_ip_q;
      tx_port_d  = tx_port_q;
      case (state_q)
         S_IDLE: begin
            // Occupancy before any same-cycle write decides the start.
            if (enable && !tx_afull && (count_q >= PW_L)) begin
               tx_ip_d   = dest_ip;
               tx_port_d = dest_port;
               wcnt_d    = '0;
               state_d   = (HEADER_ENABLE != 0) ? S_HDR : S_PAY;
            end
         end
         S_HDR: begin
            tx_valid_d = 1'b1;
            tx_data_d  = {HEADER_ID, seq_q};
            wcnt_d     = '0;
            state_d    = S_PAY;
         end
         S_PAY: begin
            pop        = 1'b1;
            tx_valid_d = 1'b1;
            tx_data_d  = mem_q[rd_ptr_q];
            wcnt_d     = wcnt_q + 1'b1;
            if (wcnt_q == PW_LAST) begin
               tx_eof_d = 1'b1;
               seq_d    = seq_q + 48'd1;
               pkt_d    = pkt_q + 32'd1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         wcnt_q     <= '0;
         seq_q      <= '0;
         tx_valid_q <= 1'b0;
         tx_eof_q   <= 1'b0;
         tx_data_q  <= '0;
         tx_ip_q    <= '0;
         tx_port_q  <= '0;
         pkt_q      <= '0;
         drop_q     <= '0;
         ovf_q      <= '0;
      end else begin
         state_q    <= state_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q    <= count_d;
         full_q     <= (count_d == DEPTH_L);
         wcnt_q     <= wcnt_d;
         seq_q      <= seq_d;
         tx_valid_q <= tx_valid_d;
         tx_eof_q   <= tx_eof_d;
         tx_data_q  <= tx_data_d;
         tx_ip_q    <= tx_ip_d;
         tx_port_q  <= tx_port_d;
         pkt_q      <= pkt_d;
         if (drop && (drop_q != '1))       drop_q <= drop_q + 32'd1;
         if (tx_overflow && (ovf_q != '1)) ovf_q  <= ovf_q + 16'd1;
      end
   end

   assign in_full         = full_q;
   assign tx_valid        = tx_valid_q;
   assign tx_end_of_frame = tx_eof_q;
   assign tx_data         = tx_data_q;
   assign tx_dest_ip      = tx_ip_q;
   assign tx_dest_port    = tx_port_q;
   assign pkt_count       = pkt_q;
   assign drop_count      = drop_q;
   assign ovf_count       = ovf_q;
   assign busy            = (state_q != S_IDLE);

endmodule
